// File: rtl/layer_scheduler_pkg.sv
// Shared types and width helpers for the layer scheduler.
package layer_scheduler_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } sched_state_t;

    // Activation word width shared with the layer engines
    localparam int CNN_DATA_WIDTH = 16;

    // Bits needed to index n items (never below 1)
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the value n (never below 1)
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Layer-engine handshake and shared activation BRAM port bundle.
interface layer_scheduler_if #(
    parameter int NUM_LAYERS = 4,
    parameter int AW         = 13,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_LAYERS-1:0]            layer_start;
    logic [NUM_LAYERS-1:0]            layer_done;
    logic [NUM_LAYERS*AW-1:0]         lyr_addr;
    logic [NUM_LAYERS-1:0]            lyr_en;
    logic [NUM_LAYERS-1:0]            lyr_we;
    logic [NUM_LAYERS*DATA_WIDTH-1:0] lyr_d;
    logic [AW-1:0]                    mem_addr;
    logic                             mem_en;
    logic                             mem_we;
    logic signed [DATA_WIDTH-1:0]     mem_d;

    // Scheduler side: launches layers and owns the BRAM port
    modport master (
        output layer_start, mem_addr, mem_en, mem_we, mem_d,
        input  layer_done, lyr_addr, lyr_en, lyr_we, lyr_d
    );

    // Layer/BRAM side
    modport slave (
        input  layer_start, mem_addr, mem_en, mem_we, mem_d,
        output layer_done, lyr_addr, lyr_en, lyr_we, lyr_d
    );
endinterface

// File: rtl/layer_scheduler_bram_mux.sv
// Zero-latency mux handing the shared BRAM port to the granted layer.
module layer_scheduler_bram_mux #(
    parameter int NUM_LAYERS = 4,
    parameter int AW         = 13,
    parameter int DATA_WIDTH = 16
) (
    input  logic [NUM_LAYERS-1:0]            grant,
    input  logic [NUM_LAYERS*AW-1:0]         lyr_addr,
    input  logic [NUM_LAYERS-1:0]            lyr_en,
    input  logic [NUM_LAYERS-1:0]            lyr_we,
    input  logic [NUM_LAYERS*DATA_WIDTH-1:0] lyr_d,
    output logic [AW-1:0]                    mem_addr,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic signed [DATA_WIDTH-1:0]     mem_d
);

    // Pass the one-hot granted request through; idle port reads as all zero
    always_comb begin
        mem_addr = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_d    = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (grant[i]) begin
                mem_addr = lyr_addr[i*AW +: AW];
                mem_en   = lyr_en[i];
                mem_we   = lyr_we[i];
                mem_d    = $signed(lyr_d[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/layer_scheduler.sv
// Frame sequencer: launches each layer in turn, grants it the shared
// activation BRAM while it runs, and aborts a layer that hangs.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int NUM_LAYERS     = 4,
    parameter int AW             = 13,
    parameter int DATA_WIDTH     = CNN_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    localparam int LW            = idx_width(NUM_LAYERS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    layer_scheduler_if.master bus,
    output logic [LW-1:0]     cur_layer,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int              TW         = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TIMER_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic            WD_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [LW-1:0]   LAST_LAYER = LW'(NUM_LAYERS - 1);

    sched_state_t          state;
    sched_state_t          state_next;
    logic [TW-1:0]         timer;
    logic                  cur_done;
    logic                  timeout;
    logic                  grant_active;
    logic [NUM_LAYERS-1:0] grant;

    // Done from any layer other than the running one is ignored
    assign cur_done = bus.layer_done[cur_layer];
    assign timeout  = WD_EN && (timer == TIMER_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next      = state;
        bus.layer_start = '0;
        busy            = 1'b0;
        done            = 1'b0;
        grant_active    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                bus.layer_start[cur_layer] = 1'b1;
                busy         = 1'b1;
                grant_active = 1'b1;
                state_next   = S_RUN;
            end
            S_RUN: begin
                busy         = 1'b1;
                grant_active = 1'b1;
                // A done arriving on the terminal count still completes the layer
                if (cur_done)     state_next = S_NEXT;
                else if (timeout) state_next = S_IDLE;
            end
            S_NEXT: begin
                busy       = 1'b1;
                state_next = (cur_layer == LAST_LAYER) ? S_FINISH : S_LAUNCH;
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Layer index, watchdog timer and sticky abort flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_layer <= '0;
            timer     <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_layer <= '0;
                        error     <= 1'b0;
                    end
                end
                S_LAUNCH: timer <= '0;
                S_RUN: begin
                    if (WD_EN) timer <= timer + TW'(1);
                    if (!cur_done && timeout) error <= 1'b1;
                end
                S_NEXT: begin
                    if (cur_layer != LAST_LAYER) cur_layer <= cur_layer + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // One-hot grant to the running layer during LAUNCH and RUN only
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            grant[i] = grant_active && (cur_layer == LW'(i));
        end
    end

    layer_scheduler_bram_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .AW         (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .grant    (grant),
        .lyr_addr (bus.lyr_addr),
        .lyr_en   (bus.lyr_en),
        .lyr_we   (bus.lyr_we),
        .lyr_d    (bus.lyr_d),
        .mem_addr (bus.mem_addr),
        .mem_en   (bus.mem_en),
        .mem_we   (bus.mem_we),
        .mem_d    (bus.mem_d)
    );

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: behavioural layer engines answer layer_start
// with a programmable-latency done; launch/done/abort events are checked
// against an ordered queue of expected events.
module tb_layer_scheduler;

    localparam int NL      = 4;
    localparam int AW      = 13;
    localparam int DW      = 16;
    localparam int TMO     = 16;
    localparam int EV_DONE = 10;
    localparam int EV_ERR  = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cur_layer;
    logic       busy;
    logic       done;
    logic       error;

    layer_scheduler_if #(.NUM_LAYERS(NL), .AW(AW), .DATA_WIDTH(DW)) bus ();

    layer_scheduler #(
        .NUM_LAYERS     (NL),
        .AW             (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cur_layer (cur_layer),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   sb[$];
    int   dly[NL];
    logic hang[NL];
    int   spur_req = 0;
    int   spur_seen = 0;
    int   cyc = 0;
    int   mon_cnt[NL];
    int   last_done_cyc = 0;
    int   last_start_cyc = 0;
    logic err_prev = 1'b0;

    typedef struct {
        logic          run;
        logic [AW-1:0] a0;
        logic          e0;
        logic          w0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic          e1;
        logic          w1;
        logic [DW-1:0] d1;
        logic [AW-1:0] xa;
        logic          xe;
        logic          xw;
        logic [DW-1:0] xd;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic expect_event(input int ev);
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected: got event %0d, want none", ev);
        end else begin
            check("sb_event", ev, sb.pop_front());
        end
    endtask

    // Monitor and layer-engine model, all on the falling edge
    initial begin
        for (int i = 0; i < NL; i++) mon_cnt[i] = 0;
        bus.layer_done = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                sb.delete();
                for (int i = 0; i < NL; i++) mon_cnt[i] = 0;
                bus.layer_done = '0;
                err_prev  = 1'b0;
                spur_seen = spur_req;
            end else begin
                if (bus.layer_start != '0) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < NL; i++)
                        if (bus.layer_start[i]) idx = (idx == -1) ? i : 99;
                    expect_event(idx);
                    check("ls_cur_layer", cur_layer, idx);
                    if (idx > 0) check("ls_gap", cyc - last_done_cyc, 2);
                    last_start_cyc = cyc;
                end
                if (done) begin
                    expect_event(EV_DONE);
                    check("done_gap", cyc - last_done_cyc, 2);
                    check("done_busy", busy, 0);
                end
                if (error && !err_prev) begin
                    expect_event(EV_ERR);
                    check("err_run_cycles", cyc - last_start_cyc - 1, TMO);
                    check("err_busy", busy, 0);
                    check("err_done", done, 0);
                end
                err_prev = error;
                bus.layer_done = '0;
                for (int i = 0; i < NL; i++) begin
                    if (mon_cnt[i] > 0) begin
                        mon_cnt[i]--;
                        if (mon_cnt[i] == 0) begin
                            bus.layer_done[i] = 1'b1;
                            last_done_cyc = cyc;
                        end
                    end
                end
                for (int i = 0; i < NL; i++)
                    if (bus.layer_start[i] && !hang[i]) mon_cnt[i] = dly[i];
                if (spur_seen != spur_req) begin
                    bus.layer_done[3] = 1'b1;
                    spur_seen = spur_req;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_lyr(input logic [AW-1:0] a0, input logic e0, input logic w0, input logic [DW-1:0] d0,
                             input logic [AW-1:0] a1, input logic e1, input logic w1, input logic [DW-1:0] d1);
        bus.lyr_addr = {13'h0AAA, 13'h0AAA, a1, a0};
        bus.lyr_en   = {1'b1, 1'b1, e1, e0};
        bus.lyr_we   = {1'b1, 1'b1, w1, w0};
        bus.lyr_d    = {16'h5555, 16'h5555, d1, d0};
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        for (int i = 0; i < NL; i++) hang[i] = 1'b0;
    endtask

    task automatic push_full();
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3);
        sb.push_back(EV_DONE);
    endtask

    task automatic start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        check(name, {31'd0, (sb.size() == 0 && !busy)}, 1);
    endtask

    task automatic wait_l1_run(input string name);
        int n;
        n = 0;
        while (!(cur_layer == 2'd1 && busy && bus.layer_start == '0) && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, (n < 100)}, 1);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_layer_start"}, bus.layer_start, 0);
        check({tag, "_cur_layer"}, cur_layer, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_mem_en"}, bus.mem_en, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_d"}, $unsigned(bus.mem_d), 0);
    endtask

    task automatic apply_row(input int r);
        drive_lyr(tbl[r].a0, tbl[r].e0, tbl[r].w0, tbl[r].d0, tbl[r].a1, tbl[r].e1, tbl[r].w1, tbl[r].d1);
        #1;
        check("mux_addr", bus.mem_addr, tbl[r].xa);
        check("mux_en", bus.mem_en, tbl[r].xe);
        check("mux_we", bus.mem_we, tbl[r].xw);
        check("mux_d", $unsigned(bus.mem_d), tbl[r].xd);
    endtask

    initial begin
        //         run   a0       e0 w0  d0        a1      e1 w1  d1        xa       xe  xw  xd
        tbl[0] = '{1'b0, 13'd5,    1, 1, 16'h0080, 13'd9,  1, 0, 16'h0000, 13'd0,    0, 0, 16'h0000};
        tbl[1] = '{1'b0, 13'h1FFF, 1, 0, 16'hFFFF, 13'd3,  1, 1, 16'h1111, 13'd0,    0, 0, 16'h0000};
        tbl[2] = '{1'b1, 13'd5,    1, 1, 16'h0080, 13'd9,  1, 0, 16'h0000, 13'd5,    1, 1, 16'h0080};
        tbl[3] = '{1'b1, 13'd5,    1, 0, 16'h0080, 13'd9,  1, 1, 16'h2222, 13'd5,    1, 0, 16'h0080};
        tbl[4] = '{1'b1, 13'h1ABC, 0, 0, 16'h7FFF, 13'd9,  1, 1, 16'h2222, 13'h1ABC, 0, 0, 16'h7FFF};
        tbl[5] = '{1'b1, 13'h1FFF, 1, 1, 16'h8000, 13'd3,  1, 1, 16'h1111, 13'h1FFF, 1, 1, 16'h8000};

        set_dly(1, 1, 1, 1);
        start = 1'b0;
        reset = 1'b1;
        drive_lyr(13'd5, 1, 1, 16'h0080, 13'd9, 1, 1, 16'h1234);
        tick();
        tick();
        check_quiet_outputs("reset");
        reset = 1'b0;

        // Full frame with uneven layer latencies
        drive_lyr('0, 0, 0, '0, '0, 0, 0, '0);
        set_dly(1, 3, 2, 5);
        push_full();
        start_frame();
        wait_quiet("frame_basic");

        // Port mux: nothing granted in IDLE, layer 0 passes through while it runs
        for (int r = 0; r < 6; r++) if (!tbl[r].run) apply_row(r);
        set_dly(14, 1, 1, 1);
        push_full();
        start_frame();
        tick();
        check("mux_cur_layer", cur_layer, 0);
        for (int r = 0; r < 6; r++) begin
            if (tbl[r].run) begin
                apply_row(r);
                tick();
            end
        end
        drive_lyr('0, 0, 0, '0, '0, 0, 0, '0);
        wait_quiet("frame_mux");

        // Watchdog abort on a hung layer 2, then a fresh start clears error
        set_dly(2, 2, 1, 1);
        hang[2] = 1'b1;
        sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(EV_ERR);
        start_frame();
        wait_quiet("frame_abort");
        check("abort_error", error, 1);
        check("abort_done", done, 0);
        set_dly(1, 1, 1, 1);
        push_full();
        start_frame();
        check("restart_error", error, 0);
        check("restart_busy", busy, 1);
        wait_quiet("frame_restart");

        // Spurious done from layer 3 and a start while busy are both ignored
        set_dly(2, 12, 1, 1);
        push_full();
        start_frame();
        wait_l1_run("reach_l1_spur");
        spur_req++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("spur_cur_layer", cur_layer, 1);
        check("spur_busy", busy, 1);
        wait_quiet("frame_spur");

        // Asynchronous reset in the middle of layer 1, then a clean restart
        set_dly(1, 12, 1, 1);
        push_full();
        start_frame();
        wait_l1_run("reach_l1_reset");
        drive_lyr('0, 0, 0, '0, 13'd9, 1, 1, 16'h1234);
        #1;
        check("l1_mem_addr", bus.mem_addr, 9);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_quiet_outputs("async");
        tick();
        reset = 1'b0;
        drive_lyr('0, 0, 0, '0, '0, 0, 0, '0);
        set_dly(1, 1, 1, 1);
        push_full();
        start_frame();
        wait_quiet("frame_after_reset");

        // Layer done on the watchdog terminal count still advances
        set_dly(1, 1, TMO, 1);
        push_full();
        start_frame();
        wait_quiet("frame_tie");
        check("tie_error", error, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
